// File: rtl/snn_pkg.sv
// Shared constants and FSM encoding for the SNN input path.
// Image geometry plus loader state codes.
package snn_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int NUM_BYTES  = 98;
  localparam int ADDR_W     = 10;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t WAIT_BYTE = 3'd1;
  localparam state_t UNPACK    = 3'd2;
  localparam state_t FIRE      = 3'd3;
  localparam state_t RUN       = 3'd4;

endpackage

// File: rtl/ram_input_unit.sv
// 784x1 input-unit RAM, one sync write port, one sync read port.
// Out-of-range write addresses are dropped.
module ram_input_unit
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              data,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_r,
  output logic              q
);

  logic mem [NUM_PIXELS];

  // Registered write and registered read.
  always_ff @(posedge clk) begin
    if (we && (addr_w < ADDR_W'(NUM_PIXELS)))
      mem[addr_w] <= data;
    q <= mem[addr_r];
  end

endmodule

// File: rtl/snn_input_loader.sv
// Byte-to-pixel unpacker feeding the SNN core input RAM.
// Loads 98 bytes LSB first, fires start, then waits for done.
module snn_input_loader
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rx_rdy,
  input  logic [ADDR_W-1:0] addr_input_unit,
  output logic              q_input,
  output logic              start,
  input  logic              done,
  output logic              busy
);

  state_t      state;
  logic [7:0]  shreg;
  logic [6:0]  byte_cnt;
  logic [2:0]  bit_cnt;
  logic        rd_vld;
  logic        ram_q;
  logic        we;
  logic [ADDR_W-1:0] addr_w;

  assign we     = (state == UNPACK);
  assign addr_w = {byte_cnt, bit_cnt};

  ram_input_unit u_ram (
    .clk    (clk),
    .data   (shreg[0]),
    .addr_w (addr_w),
    .we     (we),
    .addr_r (addr_input_unit),
    .q      (ram_q)
  );

  // Masks the unreset RAM output until the first read has completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_vld <= 1'b0;
    else        rd_vld <= 1'b1;
  end

  assign q_input = ram_q & rd_vld;

  // Load sequencer: accept byte, unpack 8 bits, fire, wait for done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      clr_rx_rdy <= 1'b0;
      start      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      clr_rx_rdy <= 1'b0;
      start      <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_rdy) begin
            shreg      <= rx_data;
            clr_rx_rdy <= 1'b1;
            busy       <= 1'b1;
            state      <= UNPACK;
          end
        end
        WAIT_BYTE: begin
          if (rx_rdy) begin
            shreg      <= rx_data;
            clr_rx_rdy <= 1'b1;
            state      <= UNPACK;
          end
        end
        UNPACK: begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_cnt == 7'(NUM_BYTES - 1)) begin
              byte_cnt <= '0;
              start    <= 1'b1;
              state    <= FIRE;
            end else begin
              byte_cnt <= byte_cnt + 7'd1;
              state    <= WAIT_BYTE;
            end
          end
        end
        FIRE: begin
          state <= RUN;
        end
        RUN: begin
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed bench for snn_input_loader.
// Drives a UART-like byte source and reads back the pixel RAM.
module tb_snn_input_loader;
  import snn_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [9:0]  addr = 10'd0;
  logic        q_input;
  logic        start;
  logic        done = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  snn_input_loader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_rdy          (rx_rdy),
    .rx_data         (rx_data),
    .clr_rx_rdy      (clr_rx_rdy),
    .addr_input_unit (addr),
    .q_input         (q_input),
    .start           (start),
    .done            (done),
    .busy            (busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_clr = 0;
  int n_start = 0;
  int last_clr = -1;
  int n_gap_bad = 0;
  int start_cyc = 0;
  int c0 = 0;
  int base_s = 0;
  int base_c = 0;
  logic [7:0] img [NUM_BYTES];

  // Pulse monitor on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (clr_rx_rdy) begin
      if (last_clr >= 0 && (cyc - last_clr) != 9) n_gap_bad++;
      last_clr = cyc;
      n_clr++;
    end
    if (start) begin
      n_start++;
      start_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int from, input int n, input int gap,
                      input int done_k);
    for (int k = from; k < from + n; k++) begin
      int w;
      rx_data = img[k];
      rx_rdy  = 1'b1;
      w = 0;
      do begin
        tick;
        w++;
      end while (!clr_rx_rdy && w < 40);
      if (!clr_rx_rdy) chk($sformatf("clr_to%0d", k), 0, 1);
      if (k == from) c0 = cyc;
      if (gap > 0 || k == done_k) rx_rdy = 1'b0;
      repeat (gap) tick;
      if (k == done_k) begin
        repeat (9) tick;
        done = 1'b1;
        tick;
        done = 1'b0;
        chk("busy_wb_done", busy, 1);
      end
    end
    rx_rdy = 1'b0;
  endtask

  task automatic wait_start;
    int w;
    w = 0;
    while (n_start == base_s && w < 40) begin
      tick;
      w++;
    end
    if (n_start == base_s) chk("start_to", 0, 1);
  endtask

  task automatic read_img;
    for (int p = 0; p < NUM_PIXELS; p++) begin
      logic [7:0] b;
      addr = 10'(p);
      tick;
      b = img[p >> 3];
      chk($sformatf("pix%0d", p), q_input, b[p & 7]);
    end
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_clr", clr_rx_rdy, 0);
    chk("rst_q", q_input, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick;

    done = 1'b1;
    tick;
    done = 1'b0;
    repeat (3) tick;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_start", n_start, 0);

    for (int k = 0; k < NUM_BYTES; k++) img[k] = 8'h01;
    base_s = n_start;
    send(0, NUM_BYTES, 0, -1);
    wait_start;
    chk("img1_start_lat", start_cyc - c0, 881);
    chk("img1_nclr", n_clr, 98);
    chk("img1_gap", n_gap_bad, 0);
    repeat (3) tick;
    chk("img1_nstart", n_start - base_s, 1);
    chk("img1_busy", busy, 1);
    read_img;
    done = 1'b1;
    tick;
    done = 1'b0;
    tick;
    chk("img1_busy_end", busy, 0);

    for (int k = 0; k < NUM_BYTES; k++) img[k] = 8'(k * 37);
    img[0] = 8'hA5;
    base_s = n_start;
    send(0, NUM_BYTES, 1, 10);
    wait_start;
    repeat (3) tick;
    chk("img2_nstart", n_start - base_s, 1);
    addr = 10'd0;
    tick;
    chk("lat_a0", q_input, 1);
    addr = 10'd1;
    chk("lat_hold", q_input, 1);
    tick;
    chk("lat_a1", q_input, 0);
    read_img;

    base_c = n_clr;
    rx_data = 8'h3C;
    rx_rdy = 1'b1;
    repeat (5) tick;
    chk("run_noclr", n_clr - base_c, 0);
    chk("run_busy", busy, 1);
    done = 1'b1;
    tick;
    done = 1'b0;
    chk("run_exit_busy", busy, 0);
    chk("run_exit_clr", clr_rx_rdy, 0);
    tick;
    chk("pend_clr", clr_rx_rdy, 1);
    chk("pend_busy", busy, 1);
    img[0] = 8'h3C;
    send(1, 49, 0, -1);
    base_s = n_start;
    rst_n = 1'b0;
    tick;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_q", q_input, 0);
    rst_n = 1'b1;
    tick;

    for (int k = 0; k < NUM_BYTES; k++) img[k] = 8'hFF;
    send(0, NUM_BYTES, 0, -1);
    wait_start;
    repeat (3) tick;
    chk("img4_nstart", n_start - base_s, 1);
    read_img;
    done = 1'b1;
    tick;
    done = 1'b0;
    tick;
    chk("img4_busy_end", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
